uart_tx_ser_buf: RTL and testbench
==================================

# uart_tx_ser_buf

Parametrised, double-buffered parallel-to-serial shifter for the UART transmit path, successor to the fixed 8-bit TX serializer. It accepts words through a valid/ready handshake into a one-entry holding register, so the next word loads while the current one is still shifting. It shifts bits out in a configurable order, one bit per `ser_en` strobe. The block sits between the TX data source and the TX FSM/mux; it also supplies the word's parity bit to the parity stage.

## Interface
- `DATA_WIDTH`, default 8: bits per word, legal range 5–9.
- `LSB_FIRST`, default 1: 1 sends bit 0 first, 0 sends bit `DATA_WIDTH-1` first.
- `IDLE_LEVEL`, default 1: reset value of `S_DATA`.
- `CLK` in 1: single clock; all state updates on its rising edge.
- `RST` in 1: reset, synchronous, active-low.
- `Data_Valid` in 1: source presents a word on `P_DATA`.
- `P_DATA` in `DATA_WIDTH`: parallel word.
- `Data_Ready` out 1: holding register empty; word accepted on an edge where `Data_Valid && Data_Ready`.
- `ser_en` in 1: bit strobe from TX FSM; one bit per high cycle.
- `ser_busy` out 1: shifter holds a word with bits remaining.
- `ser_done` out 1: one-cycle pulse, asserted in the cycle the last bit of a word is on `S_DATA`.
- `S_DATA` out 1: registered serial bit.
- `PAR_BIT` out 1: XOR (even parity) of the word in the shifter; valid while `ser_busy`.

## Operation
- The shifter has two states: EMPTY and ACTIVE. A counter `bit_cnt` of width `$clog2(DATA_WIDTH)` is cleared on every load.
- **Accept:** on an edge with `Data_Valid && Data_Ready`, `P_DATA` is written to the holding register and the holding register becomes full. `Data_Ready` equals the inverse of holding-full.
- **Source rule:** the source keeps `Data_Valid` and `P_DATA` stable until accepted.
- **Transfer:** on an edge where the holding register is full and the shifter is either EMPTY or emitting its last bit, the held word moves to the shifter. The shifter becomes ACTIVE, the holding register empties, and `PAR_BIT` is registered from the word.
- **Shift:** on an edge with `ser_en` high while ACTIVE, `S_DATA` takes the next bit and `bit_cnt` increments.
  - On the edge that emits bit index `DATA_WIDTH-1` of the send order, `ser_done` is set to 1 for one cycle.
  - On that same edge, the shifter goes EMPTY, or reloads per the transfer rule if the holding register is full.
- **`ser_en` while EMPTY:** ignored. `S_DATA`, `bit_cnt` and `ser_done` hold their values, except that `ser_done` clears.
- **`ser_en` low while ACTIVE:** everything holds; gaps between strobes are legal.
- **Simultaneous events:** a transfer (which empties the holding register) and an accept never occur on the same edge, because `Data_Ready` is low while the register is full.
- **Reset**, with `RST` low at an edge, at any point including mid-word:
  - `S_DATA`=`IDLE_LEVEL`, `ser_done`=0, `ser_busy`=0, `Data_Ready`=1, `PAR_BIT`=0.
  - `bit_cnt`=0, holding register empty.
  - Words that were held or partially shifted are discarded.

## Timing
- Accept at edge k → transfer at edge k+1 → first bit on `S_DATA` no earlier than edge k+2, if `ser_en` is high.
- `Data_Ready` rises the cycle after the transfer.
- Back-to-back words: the first bit of word n+1 appears on the `ser_en` strobe immediately after word n's last bit, with no idle strobe between them.
- `ser_done` is high for exactly one cycle per word, independent of whether `ser_en` is high in the following cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `uart_tx_pkg`:
  - default constants for `DATA_WIDTH` and `IDLE_LEVEL`;
  - the shifter state enum (EMPTY, ACTIVE);
  - a bit-order localparam helper.
- Sub-module `uart_tx_hold_reg`: one-entry holding register with a full flag, valid/ready on the input side and a pop on the output side.
- Top level contains the shifter, bit counter, parity register and `ser_done` logic.

## Test plan
- **LSB-first, single word:** `DATA_WIDTH`=8, `LSB_FIRST`=1, word 0xB4, `ser_en` held high → `S_DATA` = 0,0,1,0,1,1,0,1; `ser_done` high with the 8th bit; `PAR_BIT`=0.
- **MSB-first, single word:** `LSB_FIRST`=0, word 0xB4 → `S_DATA` = 1,0,1,1,0,1,0,0.
- **Parity and narrow width:** `DATA_WIDTH`=5, word 0x07 → `S_DATA` = 1,1,1,0,0; `PAR_BIT`=1; `ser_done` with the 5th bit.
- **Back-to-back:** 0x12 accepted, then 0x34 presented during the first word's shifting:
  - 0x34 is accepted while 0x12 is shifting, and `Data_Ready` is low until 0x34 transfers;
  - the first bit of 0x34 follows 0x12's last bit on consecutive strobes;
  - two `ser_done` pulses, 8 strobes apart.
- **Strobe gaps:** `ser_en` pattern 1,0,0,1,… → bits advance only on strobes; `ser_en` pulses while EMPTY cause no change.
- **Reset mid-word:** `RST` low after the 3rd bit of 0xFF, with 0x55 held:
  - after the edge, `S_DATA`=1, `ser_busy`=0, `Data_Ready`=1;
  - the next accepted word shifts from bit 0.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared constants, shifter state type and bit-order helper for the UART TX serializer.
package uart_tx_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_LSB_FIRST  = 1;
  localparam logic        DEF_IDLE_LEVEL = 1'b1;

  typedef enum logic {
    SH_EMPTY,
    SH_ACTIVE
  } shift_state_t;

  // Position in the shift register of the bit that leaves next.
  function automatic int unsigned out_bit_pos(input bit lsb_first, input int unsigned width);
    return lsb_first ? 0 : (width - 1);
  endfunction

endpackage

// File: rtl/uart_tx_hold_reg.sv
// One-entry holding register: valid/ready on the write side, pop on the read side.
module uart_tx_hold_reg
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ready,
  input  logic                  pop,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] held
);

  // Capture a word when empty; release it on pop. Both cannot coincide since pop needs full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full <= 1'b0;
      held <= '0;
    end else if (valid && !full) begin
      full <= 1'b1;
      held <= data;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

  assign ready = !full;

endmodule

// File: rtl/uart_tx_ser_buf.sv
// Double-buffered parallel-to-serial shifter for the UART TX path.
module uart_tx_ser_buf
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned LSB_FIRST  = DEF_LSB_FIRST,
  parameter logic        IDLE_LEVEL = DEF_IDLE_LEVEL
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Data_Valid,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Ready,
  input  logic                  ser_en,
  output logic                  ser_busy,
  output logic                  ser_done,
  output logic                  S_DATA,
  output logic                  PAR_BIT
);

  localparam int unsigned     CW       = $clog2(DATA_WIDTH);
  localparam int unsigned     OUT_POS  = out_bit_pos(LSB_FIRST != 0, DATA_WIDTH);
  localparam logic [CW-1:0]   LAST_CNT = CW'(DATA_WIDTH - 1);

  shift_state_t          state;
  logic [DATA_WIDTH-1:0] sh_word;
  logic [CW-1:0]         bit_cnt;
  logic                  hold_full;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  shift_now;
  logic                  last_bit;
  logic                  xfer;

  uart_tx_hold_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_hold (
    .clk  (CLK),
    .rst_n(RST),
    .valid(Data_Valid),
    .data (P_DATA),
    .ready(Data_Ready),
    .pop  (xfer),
    .full (hold_full),
    .held (hold_data)
  );

  // Decode shift, last-bit and transfer conditions for this edge.
  always_comb begin
    shift_now = (state == SH_ACTIVE) && ser_en;
    last_bit  = shift_now && (bit_cnt == LAST_CNT);
    xfer      = hold_full && ((state == SH_EMPTY) || last_bit);
  end

  // Shifter FSM: emit bits on strobes, pulse done on the last bit, reload from the holding register.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= SH_EMPTY;
      sh_word  <= '0;
      bit_cnt  <= '0;
      S_DATA   <= IDLE_LEVEL;
      ser_done <= 1'b0;
      PAR_BIT  <= 1'b0;
    end else begin
      ser_done <= 1'b0;
      if (shift_now) begin
        S_DATA  <= sh_word[OUT_POS];
        sh_word <= (LSB_FIRST != 0) ? (sh_word >> 1) : (sh_word << 1);
        bit_cnt <= bit_cnt + CW'(1);
        if (last_bit) begin
          ser_done <= 1'b1;
          state    <= SH_EMPTY;
        end
      end
      // Transfer is placed last so a held word overrides the last-bit EMPTY and
      // the next word's first bit follows on the very next strobe.
      if (xfer) begin
        state   <= SH_ACTIVE;
        sh_word <= hold_data;
        bit_cnt <= '0;
        PAR_BIT <= ^hold_data;
      end
    end
  end

  assign ser_busy = (state == SH_ACTIVE);

endmodule

// File: tb/tb_uart_tx_ser_buf.sv
// Directed self-checking bench for uart_tx_ser_buf (8-bit LSB, 8-bit MSB and 5-bit instances).
module tb_uart_tx_ser_buf;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST;
  logic ser_en;

  logic       lsb_valid, lsb_ready, lsb_busy, lsb_done, lsb_sdata, lsb_par;
  logic [7:0] lsb_data;
  logic       msb_valid, msb_ready, msb_busy, msb_done, msb_sdata, msb_par;
  logic [7:0] msb_data;
  logic       n5_valid, n5_ready, n5_busy, n5_done, n5_sdata, n5_par;
  logic [4:0] n5_data;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  uart_tx_ser_buf #(.DATA_WIDTH(8), .LSB_FIRST(1), .IDLE_LEVEL(1'b1)) dut_lsb (
    .CLK(CLK), .RST(RST), .Data_Valid(lsb_valid), .P_DATA(lsb_data), .Data_Ready(lsb_ready),
    .ser_en(ser_en), .ser_busy(lsb_busy), .ser_done(lsb_done), .S_DATA(lsb_sdata), .PAR_BIT(lsb_par)
  );

  uart_tx_ser_buf #(.DATA_WIDTH(8), .LSB_FIRST(0), .IDLE_LEVEL(1'b1)) dut_msb (
    .CLK(CLK), .RST(RST), .Data_Valid(msb_valid), .P_DATA(msb_data), .Data_Ready(msb_ready),
    .ser_en(ser_en), .ser_busy(msb_busy), .ser_done(msb_done), .S_DATA(msb_sdata), .PAR_BIT(msb_par)
  );

  uart_tx_ser_buf #(.DATA_WIDTH(5), .LSB_FIRST(1), .IDLE_LEVEL(1'b1)) dut_n5 (
    .CLK(CLK), .RST(RST), .Data_Valid(n5_valid), .P_DATA(n5_data), .Data_Ready(n5_ready),
    .ser_en(ser_en), .ser_busy(n5_busy), .ser_done(n5_done), .S_DATA(n5_sdata), .PAR_BIT(n5_par)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] obs, dn, rdy, bsy;
    logic        par_w1, par_w2, prev;
    int unsigned k, changes, done_at;

    RST = 1'b0; ser_en = 1'b0;
    lsb_valid = 1'b0; lsb_data = '0;
    msb_valid = 1'b0; msb_data = '0;
    n5_valid  = 1'b0; n5_data  = '0;
    tick; tick;

    // Reset state of all instances
    check("rst_lsb_sdata", 32'(lsb_sdata), 32'd1);
    check("rst_lsb_busy",  32'(lsb_busy),  32'd0);
    check("rst_lsb_ready", 32'(lsb_ready), 32'd1);
    check("rst_lsb_done",  32'(lsb_done),  32'd0);
    check("rst_lsb_par",   32'(lsb_par),   32'd0);
    check("rst_msb_sdata", 32'(msb_sdata), 32'd1);
    check("rst_msb_busy",  32'(msb_busy),  32'd0);
    check("rst_msb_ready", 32'(msb_ready), 32'd1);
    check("rst_msb_done",  32'(msb_done),  32'd0);
    check("rst_msb_par",   32'(msb_par),   32'd0);
    check("rst_n5_sdata",  32'(n5_sdata),  32'd1);
    check("rst_n5_busy",   32'(n5_busy),   32'd0);
    check("rst_n5_ready",  32'(n5_ready),  32'd1);
    check("rst_n5_done",   32'(n5_done),   32'd0);
    check("rst_n5_par",    32'(n5_par),    32'd0);
    RST = 1'b1;
    tick;

    // LSB-first 0xB4
    ser_en = 1'b1;
    lsb_data = 8'hB4; lsb_valid = 1'b1;
    tick;
    check("s1_ready_after_accept", 32'(lsb_ready), 32'd0);
    check("s1_no_bit_yet", 32'(lsb_sdata), 32'd1);
    lsb_valid = 1'b0;
    tick;
    check("s1_busy_after_xfer", 32'(lsb_busy), 32'd1);
    check("s1_ready_after_xfer", 32'(lsb_ready), 32'd1);
    check("s1_par", 32'(lsb_par), 32'd0);
    obs = '0; dn = '0;
    for (int i = 0; i < 8; i++) begin
      tick;
      obs[i] = lsb_sdata;
      dn[i]  = lsb_done;
    end
    check("s1_bits", 32'(obs[7:0]), 32'h0000_00B4);
    check("s1_done_pos", 32'(dn[7:0]), 32'h0000_0080);
    check("s1_busy_end", 32'(lsb_busy), 32'd0);
    tick;
    check("s1_done_one_cycle", 32'(lsb_done), 32'd0);

    // MSB-first 0xB4 -> 1,0,1,1,0,1,0,0
    msb_data = 8'hB4; msb_valid = 1'b1;
    tick;
    msb_valid = 1'b0;
    tick;
    check("s2_par", 32'(msb_par), 32'd0);
    obs = '0; dn = '0;
    for (int i = 0; i < 8; i++) begin
      tick;
      obs[i] = msb_sdata;
      dn[i]  = msb_done;
    end
    check("s2_bits", 32'(obs[7:0]), 32'h0000_002D);
    check("s2_done_pos", 32'(dn[7:0]), 32'h0000_0080);

    // 5-bit 0x07 -> 1,1,1,0,0, parity 1
    n5_data = 5'h07; n5_valid = 1'b1;
    tick;
    n5_valid = 1'b0;
    tick;
    check("s3_par", 32'(n5_par), 32'd1);
    check("s3_busy", 32'(n5_busy), 32'd1);
    obs = '0; dn = '0;
    for (int i = 0; i < 5; i++) begin
      tick;
      obs[i] = n5_sdata;
      dn[i]  = n5_done;
    end
    check("s3_bits", 32'(obs[4:0]), 32'h0000_0007);
    check("s3_done_pos", 32'(dn[4:0]), 32'h0000_0010);
    check("s3_ready", 32'(n5_ready), 32'd1);

    // Back-to-back 0x12 then 0x34
    lsb_data = 8'h12; lsb_valid = 1'b1;
    tick;
    lsb_data = 8'h34;
    tick;
    check("b2b_ready_after_xfer", 32'(lsb_ready), 32'd1);
    check("b2b_busy_after_xfer", 32'(lsb_busy), 32'd1);
    obs = '0; dn = '0; rdy = '0; bsy = '0; par_w1 = 1'b0; par_w2 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick;
      if (i == 0) lsb_valid = 1'b0;
      obs[i] = lsb_sdata;
      dn[i]  = lsb_done;
      rdy[i] = lsb_ready;
      bsy[i] = lsb_busy;
      if (i == 0) par_w1 = lsb_par;
      if (i == 8) par_w2 = lsb_par;
    end
    check("b2b_bits", 32'(obs), 32'h0000_3412);
    check("b2b_done", 32'(dn), 32'h0000_8080);
    check("b2b_ready", 32'(rdy), 32'h0000_FF80);
    check("b2b_busy", 32'(bsy), 32'h0000_7FFF);
    check("b2b_par_w1", 32'(par_w1), 32'd0);
    check("b2b_par_w2", 32'(par_w2), 32'd1);

    // Strobe gaps: ser_en = 1,0,0,1,0,0,...
    ser_en = 1'b0;
    lsb_data = 8'hB4; lsb_valid = 1'b1;
    tick;
    lsb_valid = 1'b0;
    tick;
    obs = '0; k = 0; changes = 0; done_at = 99; prev = lsb_sdata;
    for (int c = 0; c < 22; c++) begin
      ser_en = ((c % 3) == 0);
      tick;
      if (ser_en) begin
        obs[k] = lsb_sdata;
        k++;
      end else if (lsb_sdata !== prev) begin
        changes++;
      end
      if (lsb_done) done_at = c;
      prev = lsb_sdata;
    end
    check("gap_bits", 32'(obs[7:0]), 32'h0000_00B4);
    check("gap_strobes", k, 32'd8);
    check("gap_hold", changes, 32'd0);
    check("gap_done_at", done_at, 32'd21);

    // Strobes while EMPTY: no change (msb instance last sent a 0)
    for (int i = 0; i < 3; i++) begin
      ser_en = 1'b1;
      tick;
      check("empty_msb_sdata", 32'(msb_sdata), 32'd0);
      check("empty_lsb_done", 32'(lsb_done), 32'd0);
      check("empty_lsb_busy", 32'(lsb_busy), 32'd0);
    end

    // Reset mid-word: 0xFF shifting with 0x55 held
    lsb_data = 8'hFF; lsb_valid = 1'b1;
    tick;
    lsb_data = 8'h55;
    tick;
    tick;
    lsb_valid = 1'b0;
    tick; tick;
    check("mid_busy_pre", 32'(lsb_busy), 32'd1);
    check("mid_ready_pre", 32'(lsb_ready), 32'd0);
    RST = 1'b0;
    tick;
    check("mid_rst_sdata", 32'(lsb_sdata), 32'd1);
    check("mid_rst_busy", 32'(lsb_busy), 32'd0);
    check("mid_rst_ready", 32'(lsb_ready), 32'd1);
    check("mid_rst_done", 32'(lsb_done), 32'd0);
    check("mid_rst_par", 32'(lsb_par), 32'd0);
    RST = 1'b1;
    lsb_data = 8'h01; lsb_valid = 1'b1;
    tick;
    lsb_valid = 1'b0;
    tick;
    check("post_rst_par", 32'(lsb_par), 32'd1);
    obs = '0; dn = '0;
    for (int i = 0; i < 8; i++) begin
      tick;
      obs[i] = lsb_sdata;
      dn[i]  = lsb_done;
    end
    check("post_rst_bits", 32'(obs[7:0]), 32'h0000_0001);
    check("post_rst_done", 32'(dn[7:0]), 32'h0000_0080);
    check("post_rst_idle", 32'(lsb_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
